// File: rtl/key_scan_debounce.sv
// key_scan_debounce: scans a 3x3 active-low key matrix, samples four direct
// left-side keys, and debounces all 13 keys into clean active-high levels plus
// one-cycle press pulses for the downstream LED and sound/record logic.
module key_scan_debounce #(
  parameter int unsigned SCAN_DIV   = 12000,
  parameter int unsigned DB_SAMPLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [2:0] COL,
  input  logic [2:0] ROW,
  input  logic [3:0] LEFT_RAW,
  output logic [8:0] KEY,
  output logic [8:0] KEY_PRESS,
  output logic [3:0] LEFT_KEY,
  output logic [3:0] LEFT_PRESS
);

  localparam int unsigned PsW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
  localparam logic [PsW-1:0]  PsMax  = PsW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_SAMPLES - 1);

  typedef enum logic [1:0] {
    StCol0,
    StCol1,
    StCol2
  } col_state_e;

  // Two-flop synchronizers; reset to the released (high) level.
  logic [2:0] row_s1_q, row_s2_q;
  logic [3:0] left_s1_q, left_s2_q;

  // Scan timing.
  logic [PsW-1:0] presc_q;
  logic           tick;
  col_state_e     col_state_q;
  logic [2:0]     col_q;

  // Debounce state.
  logic [8:0]           key_q, key_d;
  logic [8:0][CntW-1:0] key_cnt_q, key_cnt_d;
  logic [8:0]           key_press_q;
  logic [3:0]           left_q, left_d;
  logic [3:0][CntW-1:0] left_cnt_q, left_cnt_d;
  logic [3:0]           left_press_q;

  // Active-high views of the synchronized inputs and the driven column.
  logic [2:0] row_p;
  logic [3:0] left_p;
  logic [2:0] col_act;

  assign row_p   = ~row_s2_q;
  assign left_p  = ~left_s2_q;
  assign col_act = ~col_q;
  assign tick    = (presc_q == PsMax);

  // Bring the asynchronous row and left-key inputs into the CLK domain.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      row_s1_q  <= 3'b111;
      row_s2_q  <= 3'b111;
      left_s1_q <= 4'hF;
      left_s2_q <= 4'hF;
    end else begin
      row_s1_q  <= ROW;
      row_s2_q  <= row_s1_q;
      left_s1_q <= LEFT_RAW;
      left_s2_q <= left_s1_q;
    end
  end

  // Free-running scan prescaler; tick marks the last cycle of each period.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Column FSM: advances on tick, same edge the current column is sampled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      col_state_q <= StCol0;
      col_q       <= 3'b110;
    end else if (tick) begin
      case (col_state_q)
        StCol0: begin
          col_state_q <= StCol1;
          col_q       <= 3'b101;
        end
        StCol1: begin
          col_state_q <= StCol2;
          col_q       <= 3'b011;
        end
        default: begin
          col_state_q <= StCol0;
          col_q       <= 3'b110;
        end
      endcase
    end
  end

  // Pad key debounce: only the keys of the driven column are sampled on tick.
  always_comb begin
    key_d     = key_q;
    key_cnt_d = key_cnt_q;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (tick && col_act[c]) begin
          if (row_p[r] == key_q[r*3+c]) begin
            key_cnt_d[r*3+c] = '0;
          end else if (key_cnt_q[r*3+c] == CntMax) begin
            key_d[r*3+c]     = row_p[r];
            key_cnt_d[r*3+c] = '0;
          end else begin
            key_cnt_d[r*3+c] = key_cnt_q[r*3+c] + 1'b1;
          end
        end
      end
    end
  end

  // Left key debounce: all four keys are sampled on every tick.
  always_comb begin
    left_d     = left_q;
    left_cnt_d = left_cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (tick) begin
        if (left_p[k] == left_q[k]) begin
          left_cnt_d[k] = '0;
        end else if (left_cnt_q[k] == CntMax) begin
          left_d[k]     = left_p[k];
          left_cnt_d[k] = '0;
        end else begin
          left_cnt_d[k] = left_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Debounced levels, counters and rising-edge press pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      key_q        <= '0;
      key_cnt_q    <= '0;
      key_press_q  <= '0;
      left_q       <= '0;
      left_cnt_q   <= '0;
      left_press_q <= '0;
    end else begin
      key_q        <= key_d;
      key_cnt_q    <= key_cnt_d;
      key_press_q  <= key_d & ~key_q;
      left_q       <= left_d;
      left_cnt_q   <= left_cnt_d;
      left_press_q <= left_d & ~left_q;
    end
  end

  assign COL        = col_q;
  assign KEY        = key_q;
  assign KEY_PRESS  = key_press_q;
  assign LEFT_KEY   = left_q;
  assign LEFT_PRESS = left_press_q;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed bench for key_scan_debounce with SCAN_DIV=8, DB_SAMPLES=4.
// Inputs change 1 ns after each rising edge and outputs are checked there;
// cyc counts rising edges since the last reset release.
module tb_key_scan_debounce;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] COL;
  logic [2:0] ROW;
  logic [3:0] LEFT_RAW;
  logic [8:0] KEY;
  logic [8:0] KEY_PRESS;
  logic [3:0] LEFT_KEY;
  logic [3:0] LEFT_PRESS;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int kp_cnt;
  int lp_cnt;
  logic [8:0] pad_held;

  always #5 CLK = ~CLK;

  key_scan_debounce #(
    .SCAN_DIV  (8),
    .DB_SAMPLES(4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .COL       (COL),
    .ROW       (ROW),
    .LEFT_RAW  (LEFT_RAW),
    .KEY       (KEY),
    .KEY_PRESS (KEY_PRESS),
    .LEFT_KEY  (LEFT_KEY),
    .LEFT_PRESS(LEFT_PRESS)
  );

  // Diode key matrix: a held key pulls its row low while its column is driven.
  function automatic logic [2:0] matrix_rows(input logic [2:0] col, input logic [8:0] held);
    logic [2:0] rows;
    int c;
    rows = 3'b111;
    case (col)
      3'b110:  c = 0;
      3'b101:  c = 1;
      3'b011:  c = 2;
      default: c = -1;
    endcase
    if (c >= 0) begin
      for (int r = 0; r < 3; r++) begin
        if (held[r*3+c]) rows[r] = 1'b0;
      end
    end
    return rows;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    ROW = matrix_rows(COL, pad_held);
  endtask

  // Step until cyc reaches target, counting cycles with any press pulse.
  task automatic run_to(input int target, output int kp, output int lp);
    kp = 0;
    lp = 0;
    while (cyc < target) begin
      step();
      if (KEY_PRESS != 9'd0) kp++;
      if (LEFT_PRESS != 4'd0) lp++;
    end
  endtask

  initial begin
    logic [2:0] exp_col;

    // 1. Reset for two cycles.
    RESET    = 1'b1;
    ROW      = 3'b111;
    LEFT_RAW = 4'hF;
    pad_held = 9'd0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc   = 0;
    check("reset_col", 32'(COL), 32'h6);
    check("reset_key", 32'(KEY), 32'h0);
    check("reset_key_press", 32'(KEY_PRESS), 32'h0);
    check("reset_left_key", 32'(LEFT_KEY), 32'h0);
    check("reset_left_press", 32'(LEFT_PRESS), 32'h0);

    // 2. Idle scan: column changes every 8 cycles, outputs stay quiet.
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k < 8) exp_col = 3'b110;
      else if (k < 16) exp_col = 3'b101;
      else if (k < 24) exp_col = 3'b011;
      else exp_col = 3'b110;
      check("idle_col", 32'(COL), 32'(exp_col));
      check("idle_outputs", 32'({KEY, KEY_PRESS, LEFT_KEY, LEFT_PRESS}), 32'h0);
    end

    // 3. Press key 4 (row 1, col 1); column-1 samples at 40,64,88,112.
    pad_held[4] = 1'b1;
    run_to(111, kp_cnt, lp_cnt);
    check("k4_before_rise", 32'(KEY), 32'h0);
    check("k4_no_early_pulse", 32'(kp_cnt), 32'd0);
    step();
    check("k4_rise_level", 32'(KEY), 32'h010);
    check("k4_rise_pulse", 32'(KEY_PRESS), 32'h010);
    step();
    check("k4_pulse_one_cycle", 32'(KEY_PRESS), 32'h0);
    check("k4_level_held", 32'(KEY), 32'h010);

    // 4. Left key 2 bounces (5-cycle toggle) from cyc 120 to 179, then holds.
    run_to(120, kp_cnt, lp_cnt);
    for (int i = 0; i < 60; i++) begin
      LEFT_RAW[2] = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      check("left_bounce_level", 32'(LEFT_KEY), 32'h0);
    end
    LEFT_RAW[2] = 1'b0;
    run_to(199, kp_cnt, lp_cnt);
    check("left_before_rise", 32'(LEFT_KEY), 32'h0);
    check("left_no_early_pulse", 32'(lp_cnt), 32'd0);
    step();
    check("left_rise_level", 32'(LEFT_KEY), 32'h4);
    check("left_rise_pulse", 32'(LEFT_PRESS), 32'h4);
    step();
    check("left_pulse_one_cycle", 32'(LEFT_PRESS), 32'h0);
    check("k4_held_during_left", 32'(KEY), 32'h010);

    // 5. Release key 4 at cyc 208; released samples at 232,256,280,304.
    run_to(208, kp_cnt, lp_cnt);
    pad_held[4] = 1'b0;
    run_to(303, kp_cnt, lp_cnt);
    check("k4_before_fall", 32'(KEY), 32'h010);
    step();
    check("k4_fall_level", 32'(KEY), 32'h0);
    check("k4_release_no_pulse", 32'(KEY_PRESS), 32'h0);
    check("release_window_pulses", 32'(kp_cnt), 32'd0);

    // 6. Press key 0 at cyc 305; column-0 samples at 320,344,368,392.
    step();
    pad_held[0] = 1'b1;
    run_to(391, kp_cnt, lp_cnt);
    check("k0_before_rise", 32'(KEY), 32'h0);
    step();
    check("k0_rise_level", 32'(KEY), 32'h001);
    check("k0_rise_pulse", 32'(KEY_PRESS), 32'h001);
    run_to(400, kp_cnt, lp_cnt);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("midreset_key", 32'(KEY), 32'h0);
    check("midreset_key_press", 32'(KEY_PRESS), 32'h0);
    check("midreset_left_key", 32'(LEFT_KEY), 32'h0);
    check("midreset_left_press", 32'(LEFT_PRESS), 32'h0);
    check("midreset_col", 32'(COL), 32'h6);

    // After reset at edge 401, ticks fall on 409,417,...; left re-asserts at 433.
    run_to(432, kp_cnt, lp_cnt);
    check("left_reassert_before", 32'(LEFT_KEY), 32'h0);
    step();
    check("left_reassert_level", 32'(LEFT_KEY), 32'h4);
    check("left_reassert_pulse", 32'(LEFT_PRESS), 32'h4);

    // Key 0 column samples at 409,433,457,481.
    run_to(480, kp_cnt, lp_cnt);
    check("k0_reassert_before", 32'(KEY), 32'h0);
    check("k0_no_pulse_after_reset", 32'(kp_cnt), 32'd0);
    step();
    check("k0_reassert_level", 32'(KEY), 32'h001);
    check("k0_reassert_pulse", 32'(KEY_PRESS), 32'h001);
    step();
    check("k0_reassert_pulse_end", 32'(KEY_PRESS), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
